// File: rtl/vga_plot_pkg.sv
// vga_plot_pkg: shared definitions for the VGA plot-port arbiter.
//   X_W, Y_W, COLOUR_W : widths of the VGA adapter coordinate and colour buses.
//   BOX_W              : side of one board box in pixels (a burst is one box).
//   state_t            : arbiter FSM states.
package vga_plot_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int COLOUR_W = 3;
  localparam int BOX_W    = 40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    index with highest priority this round
//   winner out NUM_REQ  one-hot winner (zero when no request)
//   idx    out IDX_W    index of the winner
//   any    out 1        at least one request present
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  int                 sel;

  always_comb begin
    // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
    rot = NUM_REQ'({req, req} >> ptr);
    sel = 0;
    any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) sel = int'(ptr) + k;
    end
    if (sel >= NUM_REQ) sel = sel - NUM_REQ;
    idx    = IDX_W'(sel);
    winner = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single VGA adapter plot port between the
// background, foreground and bomb renderers. One requester owns the port for a
// whole burst; owners rotate round-robin. Granted pixels reach the adapter one
// registered stage later.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req[NUM_REQ]         burst request, held for the whole burst
//   last[NUM_REQ]        final pixel of the burst (only with plot_i)
//   plot_i[NUM_REQ]      pixel valid per requester
//   x_i/y_i/colour_i     packed pixel data, requester i in slice i
//   grant[NUM_REQ]       registered one-hot grant
//   vga_x/y/colour/plot  registered adapter write port
//   busy                 arbiter not idle
//   timeout              one-cycle pulse on watchdog release
//
// Build option: define VGA_PLOT_ARB_WATCHDOG_EN to force a release after
// MAX_BURST accepted pixels without last.
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = BOX_W * BOX_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ-1:0]            plot_i,
  input  logic [NUM_REQ*X_W-1:0]        x_i,
  input  logic [NUM_REQ*Y_W-1:0]        y_i,
  input  logic [NUM_REQ*COLOUR_W-1:0]   colour_i,
  output logic [NUM_REQ-1:0]            grant,
  output logic [X_W-1:0]                vga_x,
  output logic [Y_W-1:0]                vga_y,
  output logic [COLOUR_W-1:0]           vga_colour,
  output logic                          vga_plot,
  output logic                          busy,
  output logic                          timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;

  logic [NUM_REQ-1:0]   acc_vec;
  logic                 vld_p0;
  logic [X_W-1:0]       pix_x_p0;
  logic [Y_W-1:0]       pix_y_p0;
  logic [COLOUR_W-1:0]  pix_c_p0;

  logic                 vld_p1;
  logic [X_W-1:0]       pix_x_p1;
  logic [Y_W-1:0]       pix_y_p1;
  logic [COLOUR_W-1:0]  pix_c_p1;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  // Stage p0: select the granted requester's pixel. grant_q is only non-zero in
  // BURST, so no state qualification is needed here.
  assign acc_vec = grant_q & req & plot_i;
  assign vld_p0  = |acc_vec;

  always_comb begin
    pix_x_p0 = '0;
    pix_y_p0 = '0;
    pix_c_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_vec[i]) begin
        pix_x_p0 = x_i[X_W*i +: X_W];
        pix_y_p0 = y_i[Y_W*i +: Y_W];
        pix_c_p0 = colour_i[COLOUR_W*i +: COLOUR_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = BURST;
          grant_d = win_onehot;
          ptr_d   = next_ptr(win_idx);
          cnt_d   = '0;
        end
      end
      BURST: begin
        // A dropped request aborts the burst; acc_vec is already zero then.
        if (|(grant_q & ~req)) begin
          state_d = RELEASE;
          grant_d = '0;
        end else if (vld_p0) begin
          cnt_d = sat_inc(cnt_q);
          if (|(acc_vec & last)) begin
            state_d = RELEASE;
            grant_d = '0;
          end
`ifdef VGA_PLOT_ARB_WATCHDOG_EN
          else if (cnt_q == CNT_MAX - 1'b1) begin
            state_d   = RELEASE;
            grant_d   = '0;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Stage p1: registered adapter port and control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      vld_p1    <= 1'b0;
      pix_x_p1  <= '0;
      pix_y_p1  <= '0;
      pix_c_p1  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      vld_p1    <= vld_p0;
      if (vld_p0) begin
        pix_x_p1 <= pix_x_p0;
        pix_y_p1 <= pix_y_p0;
        pix_c_p1 <= pix_c_p0;
      end
    end
  end

  assign grant      = grant_q;
  assign vga_x      = pix_x_p1;
  assign vga_y      = pix_y_p1;
  assign vga_colour = pix_c_p1;
  assign vga_plot   = vld_p1;
  assign busy       = (state_q != IDLE);
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Testbench for vga_plot_arbiter: fixed vector table, directed burst
// sequences and randomized traffic checked against a transaction-level model.
module tb_vga_plot_arbiter;

  localparam int N = 3;
`ifdef VGA_PLOT_ARB_WATCHDOG_EN
  localparam int MB = 8;
  localparam bit WD = 1'b1;
`else
  localparam int MB = 1600;
  localparam bit WD = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [N-1:0]  req, last, plot_i;
  logic [N*10-1:0] x_i;
  logic [N*9-1:0]  y_i;
  logic [N*3-1:0]  colour_i;
  logic [N-1:0]  grant;
  logic [9:0]    vga_x;
  logic [8:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot, busy, timeout;

  logic [9:0] xs [N];
  logic [8:0] ys [N];
  logic [2:0] cs [N];

  vga_plot_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .plot_i(plot_i),
    .x_i(x_i), .y_i(y_i), .colour_i(colour_i), .grant(grant),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int plots_seen = 0;
  int to_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the port, how many idle cycles remain before the
  // next arbitration, and which requester is next in the rotation.
  int         m_owner = -1;
  int         m_gap   = 0;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  bit         m_plot  = 0;
  bit         m_to    = 0;
  logic [9:0] m_x = '0;
  logic [8:0] m_y = '0;
  logic [2:0] m_c = '0;

  task automatic model_step();
    m_plot = 0;
    m_to   = 0;
    if (reset) begin
      m_owner = -1; m_gap = 0; m_ptr = 0; m_cnt = 0;
      m_x = '0; m_y = '0; m_c = '0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (plot_i[m_owner]) begin
        m_plot = 1;
        m_x = xs[m_owner]; m_y = ys[m_owner]; m_c = cs[m_owner];
        m_cnt++;
        if (last[m_owner]) begin
          m_owner = -1; m_gap = 1;
        end else if (WD && m_cnt == MB) begin
          m_owner = -1; m_gap = 1; m_to = 1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c]) begin
          m_owner = c; m_ptr = (c + 1) % N; m_cnt = 0;
          break;
        end
      end
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      x_i[10*i +: 10]     = xs[i];
      y_i[9*i +: 9]       = ys[i];
      colour_i[3*i +: 3]  = cs[i];
    end
  endtask

  // One clock: inputs present before the edge, outputs checked 1 time unit after.
  task automatic cycle(input bit check);
    pack_inputs();
    @(posedge clk);
    model_step();
    #1;
    if (vga_plot === 1'b1) plots_seen++;
    if (timeout === 1'b1) to_seen++;
    if (check) begin
      chk("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("vga_plot", 32'(vga_plot), 32'(m_plot));
      chk("vga_x", 32'(vga_x), 32'(m_x));
      chk("vga_y", 32'(vga_y), 32'(m_y));
      chk("vga_colour", 32'(vga_colour), 32'(m_c));
      chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap > 0)));
      chk("timeout", 32'(timeout), 32'(m_to));
    end
  endtask

  typedef struct {
    bit         rst;
    logic [2:0] req, plot, last;
    logic [9:0] x0, x2;
    logic [2:0] e_grant;
    bit         e_plot;
    logic [9:0] e_x;
    bit         e_busy;
  } vec_t;

  vec_t vt[15];
  logic [2:0] order[$];
  int         gaps[$];

  initial begin
    reset = 1'b1; req = '0; last = '0; plot_i = '0;
    x_i = '0; y_i = '0; colour_i = '0;
    for (int i = 0; i < N; i++) begin
      xs[i] = '0; ys[i] = 9'd80; cs[i] = 3'(i + 1);
    end

    //           rst  req     plot    last    x0     x2      grant   plot x      busy
    vt[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 10'd0,  10'd0,   3'b000, 1'b0, 10'd0,   1'b0};
    vt[1]  = '{1'b0, 3'b001, 3'b000, 3'b000, 10'd0,  10'd0,   3'b001, 1'b0, 10'd0,   1'b1};
    vt[2]  = '{1'b0, 3'b001, 3'b001, 3'b000, 10'd40, 10'd0,   3'b001, 1'b1, 10'd40,  1'b1};
    vt[3]  = '{1'b0, 3'b101, 3'b101, 3'b000, 10'd41, 10'd100, 3'b001, 1'b1, 10'd41,  1'b1};
    vt[4]  = '{1'b0, 3'b101, 3'b000, 3'b001, 10'd41, 10'd100, 3'b001, 1'b0, 10'd41,  1'b1};
    vt[5]  = '{1'b0, 3'b101, 3'b001, 3'b001, 10'd42, 10'd100, 3'b000, 1'b1, 10'd42,  1'b1};
    vt[6]  = '{1'b0, 3'b101, 3'b000, 3'b000, 10'd0,  10'd0,   3'b000, 1'b0, 10'd42,  1'b0};
    vt[7]  = '{1'b0, 3'b101, 3'b000, 3'b000, 10'd0,  10'd0,   3'b100, 1'b0, 10'd42,  1'b1};
    vt[8]  = '{1'b0, 3'b101, 3'b100, 3'b000, 10'd0,  10'd100, 3'b100, 1'b1, 10'd100, 1'b1};
    vt[9]  = '{1'b0, 3'b001, 3'b100, 3'b000, 10'd0,  10'd101, 3'b000, 1'b0, 10'd100, 1'b1};
    vt[10] = '{1'b0, 3'b001, 3'b000, 3'b000, 10'd0,  10'd0,   3'b000, 1'b0, 10'd100, 1'b0};
    vt[11] = '{1'b0, 3'b001, 3'b000, 3'b000, 10'd0,  10'd0,   3'b001, 1'b0, 10'd100, 1'b1};
    vt[12] = '{1'b0, 3'b001, 3'b001, 3'b000, 10'd7,  10'd0,   3'b001, 1'b1, 10'd7,   1'b1};
    vt[13] = '{1'b1, 3'b001, 3'b001, 3'b000, 10'd9,  10'd0,   3'b000, 1'b0, 10'd0,   1'b0};
    vt[14] = '{1'b0, 3'b011, 3'b000, 3'b000, 10'd0,  10'd0,   3'b001, 1'b0, 10'd0,   1'b1};

    for (int r = 0; r < 15; r++) begin
      reset = vt[r].rst; req = vt[r].req; plot_i = vt[r].plot; last = vt[r].last;
      xs[0] = vt[r].x0; xs[1] = '0; xs[2] = vt[r].x2;
      cycle(1'b0);
      chk($sformatf("row%0d_grant", r), 32'(grant), 32'(vt[r].e_grant));
      chk($sformatf("row%0d_plot", r), 32'(vga_plot), 32'(vt[r].e_plot));
      chk($sformatf("row%0d_x", r), 32'(vga_x), 32'(vt[r].e_x));
      chk($sformatf("row%0d_busy", r), 32'(busy), 32'(vt[r].e_busy));
      chk($sformatf("row%0d_timeout", r), 32'(timeout), 32'd0);
    end

    // Long single burst from requester 0 (box at x=40, y=80).
    reset = 1'b1; req = '0; plot_i = '0; last = '0;
    cycle(1'b1);
    reset = 1'b0; req = 3'b001;
    cycle(1'b1);
    plots_seen = 0; to_seen = 0;
`ifdef VGA_PLOT_ARB_WATCHDOG_EN
    for (int p = 0; p < 8; p++) begin
      plot_i = 3'b001; last = 3'b000;
      xs[0] = 10'(40 + p); ys[0] = 9'd80; cs[0] = 3'(p);
      cycle(1'b1);
    end
    plot_i = 3'b000;
    cycle(1'b1);
    chk("wd_grant_released", 32'(grant), 32'd0);
    req = 3'b000;
    cycle(1'b1);
    cycle(1'b1);
    chk("wd_plot_count", 32'(plots_seen), 32'd8);
    chk("wd_timeout_pulses", 32'(to_seen), 32'd1);
`else
    for (int p = 0; p < 1600; p++) begin
      plot_i = 3'b001;
      last   = (p == 1599) ? 3'b001 : 3'b000;
      xs[0] = 10'(40 + p % 40); ys[0] = 9'(80 + p / 40); cs[0] = 3'(p);
      cycle(1'b1);
      if (p == 11) chk("no_wd_grant_after_12", 32'(grant), 32'b001);
    end
    plot_i = 3'b000; last = 3'b000;
    cycle(1'b1);
    chk("box_grant_low_after_last", 32'(grant), 32'd0);
    req = 3'b000;
    cycle(1'b1);
    chk("box_plot_count", 32'(plots_seen), 32'd1600);
    chk("box_no_timeout", 32'(to_seen), 32'd0);
`endif

    // All three requesting from reset, 4-pixel bursts each.
    reset = 1'b1; req = '0; plot_i = '0; last = '0;
    cycle(1'b1);
    reset = 1'b0; req = 3'b111; plot_i = 3'b111;
    begin
      logic [2:0] prev_g;
      int         zrun;
      prev_g = '0;
      zrun = 0;
      for (int t = 0; t < 30; t++) begin
        last = (m_owner >= 0 && m_cnt == 3) ? 3'b111 : 3'b000;
        for (int i = 0; i < N; i++) xs[i] = 10'($urandom);
        cycle(1'b1);
        if (grant != 3'b000 && prev_g == 3'b000) begin
          order.push_back(grant);
          if (order.size() > 1) gaps.push_back(zrun);
        end
        zrun = (grant == 3'b000) ? zrun + 1 : 0;
        prev_g = grant;
      end
    end
    chk("rr_order_len_ok", 32'(order.size() >= 4), 32'd1);
    begin
      logic [2:0] exp_order [4];
      exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
      for (int k = 0; k < 4 && k < order.size(); k++)
        chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    end
    for (int k = 0; k < gaps.size(); k++)
      chk($sformatf("rr_gap%0d", k), 32'(gaps[k]), 32'd2);

    // Randomized traffic against the model.
    req = '0; plot_i = '0; last = '0;
    for (int t = 0; t < 4000; t++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
        plot_i[i] = ($urandom_range(0, 3) != 0);
        last[i]   = ($urandom_range(0, 11) == 0);
        xs[i] = 10'($urandom);
        ys[i] = 9'($urandom);
        cs[i] = 3'($urandom);
      end
      cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
